// File: rtl/mnist_dlayer_node_mac_pkg.sv
// mnist_dlayer_node_mac_pkg: shared defaults, framing types and finalisation helpers
package mnist_dlayer_node_mac_pkg;
  localparam int LANES_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int FRAC_W_DEF = 16;
  localparam int ACC_W_DEF = 64;
  localparam int OUT_DEPTH_DEF = 4;
  localparam int CLIP_W = 128;

  typedef enum logic {IDLE, ACCUM} state_e;

  typedef struct packed {
    logic v;
    logic first;
    logic last;
    logic relu;
  } beat_t;

  function automatic int tree_lvls(input int lanes);
    return $clog2(lanes);
  endfunction

  function automatic logic signed [CLIP_W-1:0] relu_clamp(input logic signed [CLIP_W-1:0] v, input logic en);
    return (en && v < 0) ? '0 : v;
  endfunction

  // {above max, below min} of a dw-bit signed range
  function automatic logic [1:0] clip_dir(input logic signed [CLIP_W-1:0] v, input int dw);
    logic signed [CLIP_W-1:0] mx;
    mx = '1;
    mx = mx >> (CLIP_W - dw + 1);
    return {v > mx, v < ~mx};
  endfunction
endpackage

// File: rtl/mnist_dnode_result_fifo.sv
// mnist_dnode_result_fifo: small result FIFO with simultaneous push/pop and occupancy count
module mnist_dnode_result_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_d [DEPTH], mem_q [DEPTH];
  logic [PW-1:0] wr_d, wr_q, rd_d, rd_q;
  logic [CW-1:0] cnt_d, cnt_q;
  // next-state: write slot, wrapping pointers, occupancy
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = cnt_q != '0 ? mem_q[rd_q] : '0;
  assign count = cnt_q;
endmodule

// File: rtl/mnist_dlayer_node_mac.sv
// mnist_dlayer_node_mac: pipelined multi-beat dot-product node with bias, ReLU, saturation and result FIFO
module mnist_dlayer_node_mac
  import mnist_dlayer_node_mac_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [LANES*DATA_W-1:0] a,
  input  logic [LANES*DATA_W-1:0] b,
  input  logic [DATA_W-1:0]       bias,
  input  logic                    relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_sat,
  output logic                    err
);
  localparam int TL = tree_lvls(LANES);
  localparam int NL = 1 << TL;
  localparam int MW = 2 * DATA_W;
  localparam int CW = $clog2(OUT_DEPTH + 1);

  logic signed [ACC_W-1:0] prod [NL];
  logic signed [ACC_W-1:0] tree_d [1:2*NL-1], tree_q [1:2*NL-1];
  beat_t flag_d [0:TL], flag_q [0:TL];
  logic [DATA_W-1:0] bias_d [0:TL], bias_q [0:TL];
  logic signed [ACC_W-1:0] acc_d, acc_q;
  state_e state_d, state_q;
  logic err_d, err_q, fin_v_d, fin_v_q, fin_relu_d, fin_relu_q;
  logic [CW-1:0] credits_d, credits_q, fifo_count;
  logic signed [CLIP_W-1:0] fin_val;
  logic [1:0] fin_clip;
  logic [DATA_W:0] fin_word, head_word;
  logic accept, pop;

  assign accept = in_valid && in_ready;
  assign pop = out_valid && out_ready;

  // lane products rescaled to the fixed-point grid; leaves beyond LANES pad the tree with zero
  for (genvar i = 0; i < NL; i++) begin : g_lane
    if (i < LANES) begin : g_mul
      logic signed [MW-1:0] m;
      assign m = MW'($signed(a[i*DATA_W +: DATA_W])) * MW'($signed(b[i*DATA_W +: DATA_W]));
      assign prod[i] = ACC_W'(m >>> FRAC_W);
    end else begin : g_pad
      assign prod[i] = '0;
    end
  end

  // heap-indexed adder tree (leaves NL..2NL-1, root 1) with beat flags and bias riding alongside
  always_comb begin
    for (int n = 0; n < NL; n++) tree_d[NL+n] = prod[n];
    for (int n = 1; n < NL; n++) tree_d[n] = tree_q[2*n] + tree_q[2*n+1];
    flag_d[0] = {accept, in_first, in_last, relu_en};
    bias_d[0] = bias;
    for (int k = 1; k <= TL; k++) begin
      flag_d[k] = flag_q[k-1];
      bias_d[k] = bias_q[k-1];
    end
  end

  // framing FSM at the tree output: restart with bias on first (or orphan beat), flag misframing
  always_comb begin
    acc_d = acc_q;
    state_d = state_q;
    err_d = err_q;
    fin_v_d = 1'b0;
    fin_relu_d = fin_relu_q;
    if (flag_q[TL].v) begin
      acc_d = ((flag_q[TL].first || state_q == IDLE) ? ACC_W'($signed(bias_q[TL])) : acc_q) + tree_q[1];
      err_d = err_q | (flag_q[TL].first == (state_q == ACCUM));
      state_d = flag_q[TL].last ? IDLE : ACCUM;
      fin_v_d = flag_q[TL].last;
      fin_relu_d = flag_q[TL].relu;
    end
  end

  // result credits reserve FIFO space at acceptance so the pipeline never has to stall
  always_comb begin
    credits_d = credits_q - CW'(accept && in_last) + CW'(pop);
  end

  // pipeline, accumulator and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_q <= '{default: '0};
      flag_q <= '{default: '0};
      bias_q <= '{default: '0};
      acc_q <= '0;
      state_q <= IDLE;
      err_q <= 1'b0;
      fin_v_q <= 1'b0;
      fin_relu_q <= 1'b0;
      credits_q <= CW'(OUT_DEPTH);
    end else begin
      tree_q <= tree_d;
      flag_q <= flag_d;
      bias_q <= bias_d;
      acc_q <= acc_d;
      state_q <= state_d;
      err_q <= err_d;
      fin_v_q <= fin_v_d;
      fin_relu_q <= fin_relu_d;
      credits_q <= credits_d;
    end
  end

  assign fin_val = relu_clamp(CLIP_W'(acc_q), fin_relu_q);
  assign fin_clip = clip_dir(fin_val, DATA_W);
  assign fin_word = {|fin_clip, fin_clip[1] ? {1'b0, {(DATA_W-1){1'b1}}} :
                                fin_clip[0] ? {1'b1, {(DATA_W-1){1'b0}}} : fin_val[DATA_W-1:0]};

  mnist_dnode_result_fifo #(.W(DATA_W + 1), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(fin_v_q),
    .din(fin_word),
    .pop(pop),
    .dout(head_word),
    .count(fifo_count)
  );

  assign in_ready = credits_q != '0;
  assign out_valid = fifo_count != '0;
  assign out_data = head_word[DATA_W-1:0];
  assign out_sat = head_word[DATA_W];
  assign err = err_q;
endmodule

// File: tb/tb_mnist_dlayer_node_mac.sv
// tb_mnist_dlayer_node_mac: directed scoreboard bench for the dense-layer node MAC
module tb_mnist_dlayer_node_mac;
  localparam int LANES = 10;
  localparam int DW = 32;
  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam logic [31:0] NEG1 = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid, in_ready, in_first, in_last, relu_en;
  logic [LANES*DW-1:0] a, b;
  logic [DW-1:0] bias;
  logic out_valid, out_ready, out_sat, err;
  logic [DW-1:0] out_data;

  int n_tests = 0;
  int n_fail = 0;
  logic [DW:0] sb [$];
  logic m_accum = 1'b0;
  logic m_err = 1'b0;
  longint m_acc = 0;

  always #5 clk = ~clk;

  mnist_dlayer_node_mac dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .a(a), .b(b), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard consumer: every popped result must match the oldest expectation
  always @(negedge clk) begin : mon
    logic [DW:0] e;
    if (rst_n && out_valid && out_ready) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_out: observed %h expected none", out_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("result", {out_sat, out_data}, e);
      end
    end
  end

  // offer one beat (all lanes equal), wait for acceptance, then update the reference model
  task automatic beat(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] bs,
                      input logic f, input logic l, input logic r);
    int t = 0;
    longint part = 0;
    longint v;
    in_valid = 1'b1; a = {LANES{av}}; b = {LANES{bv}}; bias = bs;
    in_first = f; in_last = l; relu_en = r;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    chk("in_ready_wait", in_ready, 1);
    if (!in_ready) begin in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < LANES; i++) part += (longint'($signed(av)) * longint'($signed(bv))) >>> 16;
    if (f == m_accum) m_err = 1'b1;
    m_acc = (f || !m_accum) ? longint'($signed(bs)) + part : m_acc + part;
    m_accum = !l;
    if (l) begin
      v = (r && m_acc < 0) ? 0 : m_acc;
      sb.push_back(v > 64'sh7FFF_FFFF ? {1'b1, 32'h7FFF_FFFF} :
                   v < -64'sh8000_0000 ? {1'b1, 32'h8000_0000} : {1'b0, v[31:0]});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    m_accum = 1'b0; m_err = 1'b0; m_acc = 0;
    sb.delete();
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin @(posedge clk); #1; t++; end
    chk("drain", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("drained_valid", out_valid, 0);
  endtask

  initial begin
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; relu_en = 1'b0;
    a = '0; b = '0; bias = '0; out_ready = 1'b1;
    #2;
    do_reset();
    // single beat 20.5 with latency check
    beat(ONE, 32'h0002_0000, 32'h0000_8000, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 5) chk("lat_not_yet", out_valid, 0);
      if (k == 6) chk("lat_valid", out_valid, 1);
    end
    drain();
    // three back-to-back beats -> 30.0
    beat(ONE, ONE, 32'h0, 1'b1, 1'b0, 1'b0);
    beat(ONE, ONE, 32'h0, 1'b0, 1'b0, 1'b0);
    beat(ONE, ONE, 32'h0, 1'b0, 1'b1, 1'b0);
    // negative result, with and without ReLU
    beat(ONE, NEG1, 32'h0, 1'b1, 1'b1, 1'b0);
    beat(ONE, NEG1, 32'h0, 1'b1, 1'b1, 1'b1);
    // saturation both ways
    beat(32'h7FFF_0000, ONE, 32'h0, 1'b1, 1'b1, 1'b0);
    beat(32'h7FFF_0000, NEG1, 32'h0, 1'b1, 1'b1, 1'b0);
    drain();
    chk("err_clean", err, m_err);
    // credit back-pressure with a full FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(ONE, ONE, 32'(i) << 16, 1'b1, 1'b1, 1'b0);
    chk("in_ready_full", in_ready, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("full_valid", out_valid, 1);
    chk("hold_head0", {out_sat, out_data}, sb[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_head1", {out_sat, out_data}, sb[0]);
    chk("in_ready_still_full", in_ready, 0);
    out_ready = 1'b1;
    beat(ONE, ONE, 32'h0004_0000, 1'b1, 1'b1, 1'b0);
    beat(ONE, ONE, 32'h0005_0000, 1'b1, 1'b1, 1'b0);
    drain();
    // orphan beat from IDLE: bias still applied, sticky error
    beat(ONE, ONE, ONE, 1'b0, 1'b1, 1'b0);
    drain();
    chk("err_set", err, m_err);
    // reset mid-vector, then a clean vector
    beat(ONE, ONE, 32'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    do_reset();
    beat(ONE, 32'h0002_0000, 32'h0000_8000, 1'b1, 1'b1, 1'b0);
    drain();
    chk("err_after_reset", err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
